uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Packet controller that sits directly behind the UART receiver and consumes its RxReady/RxData byte stream. It hunts for a start-of-frame byte, parses a length-prefixed frame with an XOR checksum, and buffers the payload internally. Validated payloads are delivered to the downstream command logic over a valid/ready stream with a last marker. Framing, length, timeout and overrun errors are flagged and counted.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (buffer depth), 1..255
SOF_BYTE, 8'hA5, start-of-frame marker
TIMEOUT_TICKS, 480, inter-byte timeout in Tick pulses (16x baud, 3 character times)

Ports:
Clock  input  1  system clock
ResetN  input  1  reset, synchronous, active-low
Tick  input  1  baud-generator oversample tick, used for the timeout only
RxReady  input  1  one-cycle pulse, RxData valid
RxData  input  8  received byte
OutValid  output  1  payload byte available
OutData  output  8  payload byte
OutLast  output  1  marks final payload byte of the frame
OutReady  input  1  downstream accepts byte when OutValid&&OutReady
FrameOk  output  1  one-cycle pulse, frame passed checksum
ErrChecksum  output  1  one-cycle pulse
ErrLength  output  1  one-cycle pulse
ErrTimeout  output  1  one-cycle pulse
ErrOverrun  output  1  one-cycle pulse
ErrCount  output  8  saturating count of all error pulses
Busy  output  1  state != HUNT

Behaviour:
- Reset (ResetN=0 at posedge): state HUNT. All pulses, OutValid, OutLast and Busy are 0. ErrCount, length, indices, checksum and timeout counter are 0. Buffer contents are not cleared. A reset mid-frame or mid-drain abandons the frame with no error pulse.
- States: HUNT, LEN, PAYLOAD, CHECK, DRAIN.
- HUNT: a byte equal to SOF_BYTE goes to LEN. Any other byte is dropped silently.
- LEN: a byte L with 1<=L<=MAX_LEN stores Len=L, sets Csum=L, sets WrIdx=0, and goes to PAYLOAD. L=0 or L>MAX_LEN pulses ErrLength and goes to HUNT.
- PAYLOAD: each byte is written to Buf[WrIdx] and XORed into Csum, then WrIdx increments. When the byte with WrIdx==Len-1 is accepted, go to CHECK.
- CHECK: compare the byte with Csum.
  - Match: go to DRAIN, set RdIdx=0, pulse FrameOk in the next cycle (the first DRAIN cycle).
  - Mismatch: pulse ErrChecksum and go to HUNT.
- DRAIN:
  - OutValid=1 and OutData=Buf[RdIdx], both combinational from registers. OutLast=(RdIdx==Len-1).
  - On OutValid&&OutReady, RdIdx increments. The transfer with OutLast=1 returns to HUNT the next cycle.
  - OutData and OutLast stay stable while OutReady=0.
  - Any RxReady in DRAIN drops the byte and pulses ErrOverrun. The drain is unaffected.
- Error-pulse timing: all error pulses and FrameOk are registered, asserted the cycle after the causing event.
- Timeout:
  - In LEN, PAYLOAD and CHECK, a counter increments on each Tick and clears on each RxReady and on state entry.
  - When the counter reaches TIMEOUT_TICKS, pulse ErrTimeout and go to HUNT.
  - If RxReady and the terminal Tick coincide, the byte wins: it is processed and the counter cleared.
  - The counter is inactive in HUNT and DRAIN.
- ErrCount: +1 per error pulse, saturating at 255. Error conditions are mutually exclusive per cycle.
- Counter width: the timeout counter is $clog2(TIMEOUT_TICKS+1) bits.
- Latency: the first OutValid appears 1 cycle after the RxReady carrying the checksum byte.

Test Plan:
1. Good frame A5 03 11 22 33 03 (checksum 0x03), OutReady=1 → OutData 11,22,33 on consecutive cycles; OutLast only with 33; FrameOk pulses once; ErrCount=0; Busy low after drain.
2. Bad checksum A5 02 AA 55 00 (expected FD) → ErrChecksum pulse; OutValid never asserts; ErrCount=1; a following good frame is delivered.
3. Length errors A5 00, then A5 11 with MAX_LEN=16 → two ErrLength pulses; ErrCount=2; state HUNT; leading garbage 00 FF before SOF causes no pulses.
4. Timeout A5 02 10, then no bytes → ErrTimeout exactly on the cycle after the 480th Tick; HUNT. A repeat where the byte arrives on the 480th Tick → no timeout, frame completes.
5. Backpressure/overrun: good frame, OutReady=0 for 50 cycles, inject RxReady → ErrOverrun pulse; OutData holds 11; release OutReady → full payload delivered intact.
6. Reset asserted mid-PAYLOAD and mid-DRAIN → next cycle OutValid=0, Busy=0, ErrCount=0, no error pulse; a subsequent good frame is accepted. Force 300 errors → ErrCount saturates at 255.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream bundle around the frame controller.
// Upstream: RxReady/RxData from the UART receiver.
// Downstream: OutValid/OutData/OutLast with OutReady backpressure.
// slave  : the frame controller side.
// master : the side that drives received bytes and OutReady, and consumes the payload.
interface uart_rx_frame_ctrl_if;
    logic       RxReady;
    logic [7:0] RxData;
    logic       OutValid;
    logic [7:0] OutData;
    logic       OutLast;
    logic       OutReady;

    modport master (
        output RxReady, RxData, OutReady,
        input  OutValid, OutData, OutLast
    );

    modport slave (
        input  RxReady, RxData, OutReady,
        output OutValid, OutData, OutLast
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Hunts for SOF_BYTE, then reads a length byte, the payload and an XOR checksum.
// The checksum covers the length byte and the payload. Good frames are buffered
// and drained over a valid/ready stream. Bad frames raise a one-cycle error pulse.
// Ports:
//   Clock, ResetN     clock, synchronous active-low reset
//   Tick              oversample tick; drives only the inter-byte timeout
//   bus (slave)       RxReady/RxData in; OutValid/OutData/OutLast out; OutReady in
//   FrameOk           pulse: frame passed its checksum
//   Err*              one-cycle error pulses (checksum, length, timeout, overrun)
//   ErrCount          saturating count of all error pulses
//   Busy              controller is not hunting for SOF
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SOF_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_TICKS = 480
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Tick,
    uart_rx_frame_ctrl_if.slave   bus,
    output logic                  FrameOk,
    output logic                  ErrChecksum,
    output logic                  ErrLength,
    output logic                  ErrTimeout,
    output logic                  ErrOverrun,
    output logic [7:0]            ErrCount,
    output logic                  Busy
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TCNT_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    // Counter value at which the next Tick is the terminal one.
    localparam logic [TCNT_W-1:0] TOUT_LAST = TCNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    last_idx_q;
    logic [IDX_W-1:0]    wr_idx_q;
    logic [IDX_W-1:0]    rd_idx_q;
    logic [7:0]          csum_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [7:0]          buf_q [MAX_LEN];

    logic timing_st;
    logic tout_ev;
    logic len_err_ev;
    logic csum_ok_ev;
    logic csum_err_ev;
    logic ovr_ev;
    logic out_xfer;
    logic err_ev;

    // Per-cycle events; the states they depend on are disjoint, so at most one fires.
    assign timing_st   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // A byte arriving with the terminal Tick takes priority over the timeout.
    assign tout_ev     = timing_st && Tick && !bus.RxReady && (tcnt_q == TOUT_LAST);
    assign len_err_ev  = (state_q == S_LEN) && bus.RxReady &&
                         ((bus.RxData == 8'd0) || (bus.RxData > MAX_LEN_B));
    assign csum_ok_ev  = (state_q == S_CHECK) && bus.RxReady && (bus.RxData == csum_q);
    assign csum_err_ev = (state_q == S_CHECK) && bus.RxReady && (bus.RxData != csum_q);
    assign ovr_ev      = (state_q == S_DRAIN) && bus.RxReady;
    assign out_xfer    = (state_q == S_DRAIN) && bus.OutReady;
    assign err_ev      = tout_ev || len_err_ev || csum_err_ev || ovr_ev;

    // Stream outputs come straight from the drain registers so they hold under backpressure.
    assign bus.OutValid = (state_q == S_DRAIN);
    assign bus.OutData  = buf_q[rd_idx_q];
    assign bus.OutLast  = (state_q == S_DRAIN) && (rd_idx_q == last_idx_q);
    assign Busy         = (state_q != S_HUNT);

    // Frame FSM, timeout counter, status pulses and error counter.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q     <= S_HUNT;
            last_idx_q  <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            csum_q      <= '0;
            tcnt_q      <= '0;
            FrameOk     <= 1'b0;
            ErrChecksum <= 1'b0;
            ErrLength   <= 1'b0;
            ErrTimeout  <= 1'b0;
            ErrOverrun  <= 1'b0;
            ErrCount    <= '0;
        end else begin
            FrameOk     <= csum_ok_ev;
            ErrChecksum <= csum_err_ev;
            ErrLength   <= len_err_ev;
            ErrTimeout  <= tout_ev;
            ErrOverrun  <= ovr_ev;

            if (err_ev && (ErrCount != 8'hFF)) begin
                ErrCount <= ErrCount + 8'd1;
            end

            // Timer runs only while a frame is being received; any byte restarts it.
            if (!timing_st || bus.RxReady || tout_ev) begin
                tcnt_q <= '0;
            end else if (Tick) begin
                tcnt_q <= tcnt_q + TCNT_W'(1);
            end

            case (state_q)
                S_HUNT: begin
                    if (bus.RxReady && (bus.RxData == SOF_BYTE)) begin
                        state_q <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (bus.RxReady) begin
                        if (len_err_ev) begin
                            state_q <= S_HUNT;
                        end else begin
                            last_idx_q <= IDX_W'(bus.RxData - 8'd1);
                            csum_q     <= bus.RxData;
                            wr_idx_q   <= '0;
                            state_q    <= S_PAYLOAD;
                        end
                    end else if (tout_ev) begin
                        state_q <= S_HUNT;
                    end
                end
                S_PAYLOAD: begin
                    if (bus.RxReady) begin
                        csum_q   <= csum_q ^ bus.RxData;
                        wr_idx_q <= wr_idx_q + IDX_W'(1);
                        if (wr_idx_q == last_idx_q) begin
                            state_q <= S_CHECK;
                        end
                    end else if (tout_ev) begin
                        state_q <= S_HUNT;
                    end
                end
                S_CHECK: begin
                    if (csum_ok_ev) begin
                        rd_idx_q <= '0;
                        state_q  <= S_DRAIN;
                    end else if (csum_err_ev || tout_ev) begin
                        state_q <= S_HUNT;
                    end
                end
                S_DRAIN: begin
                    if (out_xfer) begin
                        if (rd_idx_q == last_idx_q) begin
                            state_q <= S_HUNT;
                        end else begin
                            rd_idx_q <= rd_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= S_HUNT;
            endcase
        end
    end

    // Payload buffer; deliberately not reset.
    always_ff @(posedge Clock) begin
        if ((state_q == S_PAYLOAD) && bus.RxReady) begin
            buf_q[wr_idx_q] <= bus.RxData;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: frame vector table plus hand-written
// sequences for latency, timeout, backpressure/overrun, reset and saturation.
module tb_uart_rx_frame_ctrl;

    logic       Clock  = 1'b0;
    logic       ResetN = 1'b0;
    logic       Tick   = 1'b0;
    logic       FrameOk, ErrChecksum, ErrLength, ErrTimeout, ErrOverrun, Busy;
    logic [7:0] ErrCount;

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl #(
        .MAX_LEN      (16),
        .SOF_BYTE     (8'hA5),
        .TIMEOUT_TICKS(480)
    ) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Tick       (Tick),
        .bus        (bus),
        .FrameOk    (FrameOk),
        .ErrChecksum(ErrChecksum),
        .ErrLength  (ErrLength),
        .ErrTimeout (ErrTimeout),
        .ErrOverrun (ErrOverrun),
        .ErrCount   (ErrCount),
        .Busy       (Busy)
    );

    always #5 Clock = ~Clock;

    int nchk = 0;
    int nerr = 0;
    int exp_err = 0;
    int cnt_ok = 0, cnt_cs = 0, cnt_len = 0, cnt_to = 0, cnt_ovr = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [0:7][7:0] stim;
        int unsigned     n;
        logic [0:3][7:0] pay;
        int unsigned     npay;
        int unsigned     e_ok;
        int unsigned     e_cs;
        int unsigned     e_len;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RxData  = b;
        bus.RxReady = 1'b1;
        step();
        bus.RxReady = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            Tick = 1'b1;
            step();
            Tick = 1'b0;
            step();
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (Busy && c < budget) begin
            step();
            c++;
        end
        chk("wait_idle", 32'(Busy), 32'd0);
    endtask

    // Pulse counters and payload scoreboard, sampled mid-cycle.
    always @(negedge Clock) begin
        cnt_ok  += int'(FrameOk);
        cnt_cs  += int'(ErrChecksum);
        cnt_len += int'(ErrLength);
        cnt_to  += int'(ErrTimeout);
        cnt_ovr += int'(ErrOverrun);
        if (bus.OutValid && bus.OutReady) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_out: got=%0h expected=none at %0t", bus.OutData, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(bus.OutData), 32'(e.data));
                chk("out_last", 32'(bus.OutLast), 32'(e.last));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int b_ok, b_cs, b_len, b_to, b_ovr;
        logic [7:0] cs;

        vecs[0] = '{stim: {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00}, n: 6,
                    pay: {8'h11, 8'h22, 8'h33, 8'h00}, npay: 3, e_ok: 1, e_cs: 0, e_len: 0};
        vecs[1] = '{stim: {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, n: 5,
                    pay: '0, npay: 0, e_ok: 0, e_cs: 1, e_len: 0};
        vecs[2] = '{stim: {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00}, n: 5,
                    pay: {8'hA5, 8'hA5, 8'h00, 8'h00}, npay: 2, e_ok: 1, e_cs: 0, e_len: 0};
        vecs[3] = '{stim: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                    pay: '0, npay: 0, e_ok: 0, e_cs: 0, e_len: 1};
        vecs[4] = '{stim: {8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                    pay: '0, npay: 0, e_ok: 0, e_cs: 0, e_len: 1};
        vecs[5] = '{stim: {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00}, n: 6,
                    pay: {8'h7E, 8'h00, 8'h00, 8'h00}, npay: 1, e_ok: 1, e_cs: 0, e_len: 0};

        bus.RxReady  = 1'b0;
        bus.RxData   = 8'h00;
        bus.OutReady = 1'b1;

        // Reset state
        ResetN = 1'b0;
        repeat (2) step();
        ResetN = 1'b1;
        chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
        chk("rst_outlast", 32'(bus.OutLast), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_errcount", 32'(ErrCount), 32'd0);
        chk("rst_pulses", 32'({FrameOk, ErrChecksum, ErrLength, ErrTimeout, ErrOverrun}), 32'd0);

        // Good frame with cycle-exact latency and streaming
        push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h03);
        chk("lat_outvalid", 32'(bus.OutValid), 32'd1);
        chk("lat_frameok", 32'(FrameOk), 32'd1);
        chk("lat_data0", 32'(bus.OutData), 32'h11);
        step();
        chk("stream_data1", 32'(bus.OutData), 32'h22);
        chk("frameok_once", 32'(FrameOk), 32'd0);
        step();
        chk("stream_data2", 32'(bus.OutData), 32'h33);
        chk("stream_last", 32'(bus.OutLast), 32'd1);
        step();
        chk("drain_done_busy", 32'(Busy), 32'd0);
        chk("drain_done_valid", 32'(bus.OutValid), 32'd0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            b_ok = cnt_ok; b_cs = cnt_cs; b_len = cnt_len;
            for (int j = 0; j < int'(vecs[i].npay); j++)
                push_exp(vecs[i].pay[j], j == int'(vecs[i].npay) - 1);
            for (int j = 0; j < int'(vecs[i].n); j++)
                send_byte(vecs[i].stim[j]);
            wait_idle(100);
            step();
            exp_err += int'(vecs[i].e_cs + vecs[i].e_len);
            chk($sformatf("vec%0d_ok", i), 32'(cnt_ok - b_ok), 32'(vecs[i].e_ok));
            chk($sformatf("vec%0d_cs", i), 32'(cnt_cs - b_cs), 32'(vecs[i].e_cs));
            chk($sformatf("vec%0d_len", i), 32'(cnt_len - b_len), 32'(vecs[i].e_len));
            chk($sformatf("vec%0d_errcount", i), 32'(ErrCount), 32'(exp_err));
            chk($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'd0);
        end

        // Maximum length frame
        b_ok = cnt_ok;
        cs = 8'd16;
        send_byte(8'hA5); send_byte(8'd16);
        for (int i = 0; i < 16; i++) begin
            push_exp(8'(i * 7 + 1), i == 15);
            cs = cs ^ 8'(i * 7 + 1);
            send_byte(8'(i * 7 + 1));
        end
        send_byte(cs);
        wait_idle(100);
        step();
        chk("maxlen_ok", 32'(cnt_ok - b_ok), 32'd1);
        chk("maxlen_sb_empty", 32'(sb.size()), 32'd0);

        // Timeout after the 480th Tick
        b_to = cnt_to;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        tick_n(479);
        chk("tout_pre_busy", 32'(Busy), 32'd1);
        chk("tout_pre_count", 32'(cnt_to - b_to), 32'd0);
        Tick = 1'b1;
        step();
        Tick = 1'b0;
        chk("tout_pulse", 32'(ErrTimeout), 32'd1);
        chk("tout_busy", 32'(Busy), 32'd0);
        step();
        chk("tout_pulse_end", 32'(ErrTimeout), 32'd0);
        exp_err++;
        chk("tout_errcount", 32'(ErrCount), 32'(exp_err));

        // Byte coincident with the terminal Tick wins
        b_to = cnt_to; b_ok = cnt_ok;
        push_exp(8'h10, 1'b0); push_exp(8'h20, 1'b1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        tick_n(479);
        Tick = 1'b1;
        bus.RxData = 8'h20;
        bus.RxReady = 1'b1;
        step();
        Tick = 1'b0;
        bus.RxReady = 1'b0;
        chk("race_no_tout", 32'(ErrTimeout), 32'd0);
        chk("race_busy", 32'(Busy), 32'd1);
        send_byte(8'h02 ^ 8'h10 ^ 8'h20);
        wait_idle(100);
        step();
        chk("race_to_count", 32'(cnt_to - b_to), 32'd0);
        chk("race_ok", 32'(cnt_ok - b_ok), 32'd1);

        // Backpressure and overrun
        b_ovr = cnt_ovr;
        bus.OutReady = 1'b0;
        push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h03);
        repeat (50) step();
        chk("bp_valid", 32'(bus.OutValid), 32'd1);
        chk("bp_data_hold", 32'(bus.OutData), 32'h11);
        chk("bp_last_hold", 32'(bus.OutLast), 32'd0);
        send_byte(8'h5A);
        chk("ovr_pulse", 32'(ErrOverrun), 32'd1);
        chk("ovr_data_hold", 32'(bus.OutData), 32'h11);
        step();
        chk("ovr_pulse_end", 32'(ErrOverrun), 32'd0);
        bus.OutReady = 1'b1;
        wait_idle(100);
        step();
        exp_err++;
        chk("ovr_count", 32'(cnt_ovr - b_ovr), 32'd1);
        chk("ovr_errcount", 32'(ErrCount), 32'(exp_err));
        chk("ovr_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-payload
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        chk("midpay_busy", 32'(Busy), 32'd1);
        ResetN = 1'b0;
        step();
        chk("midpay_rst_valid", 32'(bus.OutValid), 32'd0);
        chk("midpay_rst_busy", 32'(Busy), 32'd0);
        chk("midpay_rst_errcount", 32'(ErrCount), 32'd0);
        chk("midpay_rst_pulses", 32'({FrameOk, ErrChecksum, ErrLength, ErrTimeout, ErrOverrun}), 32'd0);
        ResetN = 1'b1;
        exp_err = 0;

        // Reset mid-drain
        bus.OutReady = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h03);
        chk("middrain_valid", 32'(bus.OutValid), 32'd1);
        ResetN = 1'b0;
        step();
        chk("middrain_rst_valid", 32'(bus.OutValid), 32'd0);
        chk("middrain_rst_busy", 32'(Busy), 32'd0);
        chk("middrain_rst_pulses", 32'({FrameOk, ErrChecksum, ErrLength, ErrTimeout, ErrOverrun}), 32'd0);
        ResetN = 1'b1;
        bus.OutReady = 1'b1;
        step();

        // Frame accepted after reset
        b_ok = cnt_ok;
        push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h03);
        wait_idle(100);
        step();
        chk("post_rst_ok", 32'(cnt_ok - b_ok), 32'd1);
        chk("post_rst_errcount", 32'(ErrCount), 32'd0);

        // Error counter saturation
        b_len = cnt_len;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5);
            send_byte(8'h00);
            if (i == 253) chk("sat_254", 32'(ErrCount), 32'd254);
        end
        step();
        chk("sat_len_pulses", 32'(cnt_len - b_len), 32'd300);
        chk("sat_255", 32'(ErrCount), 32'd255);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
